// File: rtl/spi_read_sequencer.sv
// SPI read-transaction sequencer: WR_BYTES write strobes, wait for master idle, pop RD_BYTES into one word.
// Optional WAIT timeout enabled by defining SPI_SEQ_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | CS high, waiting for Start_i
// WRITE   | CS low, one SPI_Write_o strobe per cycle
// GUARD   | one quiet cycle so the master can raise SPI_Transmission_i
// WAIT    | waiting for SPI_Transmission_i to fall (or timeout)
// READ    | one SPI_ReadNext_o pop per cycle, bytes captured MSB first
// DONE    | Done_o pulse; restarts immediately if Start_i is high
module spi_read_sequencer #(
   parameter int WR_BYTES       = 2,
   parameter int RD_BYTES       = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  Clk_i,
   input  logic                  Reset_n_i,
   input  logic                  Start_i,
   output logic                  Done_o,
   output logic                  Busy_o,
   output logic                  Error_o,
   output logic                  CS_n_o,
   output logic                  SPI_Write_o,
   output logic                  SPI_ReadNext_o,
   input  logic                  SPI_Transmission_i,
   input  logic [7:0]            SPI_Data_i,
   output logic [8*RD_BYTES-1:0] Data_o
);

   localparam int MAXB = (WR_BYTES > RD_BYTES) ? WR_BYTES : RD_BYTES;
   localparam int CW   = $clog2(MAXB + 1);
   localparam int DW   = 8 * RD_BYTES;

   if (WR_BYTES < 1 || WR_BYTES > 8 || RD_BYTES < 1 || RD_BYTES > 8 ||
       TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
      $error("spi_read_sequencer: parameter out of range");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_GUARD, S_WAIT, S_READ, S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] rd_idx;
   logic          rd_last;
   logic          timeout_hit;
   logic [DW-1:0] shadow_q, data_q, merged;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      rd_idx         = '0;
      rd_last        = 1'b0;
      CS_n_o         = 1'b1;
      SPI_Write_o    = 1'b0;
      SPI_ReadNext_o = 1'b0;
      Done_o         = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            Done_o  = (state_q == S_DONE);
            state_d = S_IDLE;
            if (Start_i) begin
               CS_n_o      = 1'b0;
               SPI_Write_o = 1'b1;
               cnt_d       = CW'(1);
               state_d     = (WR_BYTES == 1) ? S_GUARD : S_WRITE;
            end
         end
         S_WRITE: begin
            CS_n_o      = 1'b0;
            SPI_Write_o = 1'b1;
            cnt_d       = cnt_q + CW'(1);
            if (cnt_q == CW'(WR_BYTES - 1)) state_d = S_GUARD;
         end
         S_GUARD: begin
            CS_n_o  = 1'b0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            CS_n_o = 1'b0;
            if (!SPI_Transmission_i) begin
               SPI_ReadNext_o = 1'b1;
               cnt_d          = CW'(1);
               if (RD_BYTES == 1) begin
                  rd_last = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_READ;
               end
            end else if (timeout_hit) begin
               state_d = S_DONE;
            end
         end
         S_READ: begin
            CS_n_o         = 1'b0;
            SPI_ReadNext_o = 1'b1;
            rd_idx         = cnt_q;
            cnt_d          = cnt_q + CW'(1);
            if (cnt_q == CW'(RD_BYTES - 1)) begin
               rd_last = 1'b1;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Last byte bypasses the shadow so Data_o updates as one word
   always_comb begin
      merged      = shadow_q;
      merged[7:0] = SPI_Data_i;
   end

   always_ff @(posedge Clk_i or negedge Reset_n_i) begin
      if (!Reset_n_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         shadow_q <= '0;
         data_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (SPI_ReadNext_o) begin
            for (int k = 0; k < RD_BYTES; k++) begin
               if (rd_idx == CW'(k)) shadow_q[8*(RD_BYTES-k)-1 -: 8] <= SPI_Data_i;
            end
         end
         if (rd_last) data_q <= merged;
      end
   end

`ifdef SPI_SEQ_TIMEOUT_EN
   logic [15:0] to_cnt_q;
   logic        err_q;

   assign timeout_hit = (state_q == S_WAIT) && SPI_Transmission_i &&
                        (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge Clk_i or negedge Reset_n_i) begin
      if (!Reset_n_i) begin
         to_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state_q == S_GUARD) to_cnt_q <= '0;
         else if (state_q == S_WAIT && SPI_Transmission_i) to_cnt_q <= to_cnt_q + 16'd1;
         err_q <= timeout_hit;
      end
   end

   assign Error_o = (state_q == S_DONE) && err_q;
`else
   assign timeout_hit = 1'b0;
   assign Error_o     = 1'b0;
`endif

   assign Busy_o = (state_q != S_IDLE);
   assign Data_o = data_q;

endmodule

// File: tb/tb_spi_read_sequencer.sv
// Directed bench for spi_read_sequencer: default 2/2 instance plus a WR=1/RD=4 instance.
module tb_spi_read_sequencer;

   logic        Clk_i     = 1'b0;
   logic        Reset_n_i = 1'b0;
   logic        start_a   = 1'b0;
   logic        start_b   = 1'b0;
   logic        trans     = 1'b0;
   logic [7:0]  spi_data;

   logic        done_a, busy_a, err_a, csn_a, wr_a, rn_a;
   logic [15:0] data_a;
   logic        done_b, busy_b, err_b, csn_b, wr_b, rn_b;
   logic [31:0] data_b;

   logic [7:0]  mem [64];
   logic [5:0]  ptr = '0;
   int wr_n_a = 0, rn_n_a = 0, done_n_a = 0;
   int wr_n_b = 0, rn_n_b = 0, done_n_b = 0;
   int checks = 0, failures = 0;

   always #5 Clk_i = ~Clk_i;

   assign spi_data = mem[ptr];

   spi_read_sequencer dut_a (
      .Clk_i(Clk_i), .Reset_n_i(Reset_n_i), .Start_i(start_a),
      .Done_o(done_a), .Busy_o(busy_a), .Error_o(err_a), .CS_n_o(csn_a),
      .SPI_Write_o(wr_a), .SPI_ReadNext_o(rn_a),
      .SPI_Transmission_i(trans), .SPI_Data_i(spi_data), .Data_o(data_a)
   );

   spi_read_sequencer #(.WR_BYTES(1), .RD_BYTES(4)) dut_b (
      .Clk_i(Clk_i), .Reset_n_i(Reset_n_i), .Start_i(start_b),
      .Done_o(done_b), .Busy_o(busy_b), .Error_o(err_b), .CS_n_o(csn_b),
      .SPI_Write_o(wr_b), .SPI_ReadNext_o(rn_b),
      .SPI_Transmission_i(trans), .SPI_Data_i(spi_data), .Data_o(data_b)
   );

   // FIFO head advances and strobes are tallied on the edge that consumes them
   always @(posedge Clk_i) begin
      if (rn_a || rn_b) ptr <= ptr + 6'd1;
      if (wr_a) wr_n_a++;
      if (rn_a) rn_n_a++;
      if (done_a) done_n_a++;
      if (wr_b) wr_n_b++;
      if (rn_b) rn_n_b++;
      if (done_b) done_n_b++;
   end

   task automatic load(input logic [7:0] v, input int off);
      mem[6'(int'(ptr) + off)] = v;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge Clk_i);
         start_a = 1'b0; start_b = 1'b0; trans = 1'b0;
      end
   endtask

   task automatic test_reset;
      Reset_n_i = 1'b0;
      #2;
      if (csn_a !== 1'b1) begin $display("FAIL reset_csn_a got=%b exp=1", csn_a); failures++; end checks++;
      if (wr_a !== 1'b0) begin $display("FAIL reset_wr_a got=%b exp=0", wr_a); failures++; end checks++;
      if (rn_a !== 1'b0) begin $display("FAIL reset_rn_a got=%b exp=0", rn_a); failures++; end checks++;
      if (done_a !== 1'b0) begin $display("FAIL reset_done_a got=%b exp=0", done_a); failures++; end checks++;
      if (err_a !== 1'b0) begin $display("FAIL reset_err_a got=%b exp=0", err_a); failures++; end checks++;
      if (busy_a !== 1'b0) begin $display("FAIL reset_busy_a got=%b exp=0", busy_a); failures++; end checks++;
      if (data_a !== 16'h0) begin $display("FAIL reset_data_a got=%h exp=0000", data_a); failures++; end checks++;
      if (csn_b !== 1'b1) begin $display("FAIL reset_csn_b got=%b exp=1", csn_b); failures++; end checks++;
      if (data_b !== 32'h0) begin $display("FAIL reset_data_b got=%h exp=0", data_b); failures++; end checks++;
      @(negedge Clk_i);
      Reset_n_i = 1'b1;
      idle(2);
   endtask

   task automatic test_basic;
      int w0, r0, d0;
      logic ew, er, ed, ec;
      w0 = wr_n_a; r0 = rn_n_a; d0 = done_n_a;
      load(8'h12, 0); load(8'h34, 1);
      for (int c = 0; c <= 20; c++) begin
         @(negedge Clk_i);
         start_a = (c == 0); trans = (c < 16);
         #1;
         ew = (c < 2); er = (c == 16 || c == 17); ed = (c == 18); ec = (c > 17);
         if (wr_a !== ew) begin $display("FAIL basic_wr c=%0d got=%b exp=%b", c, wr_a, ew); failures++; end checks++;
         if (rn_a !== er) begin $display("FAIL basic_rn c=%0d got=%b exp=%b", c, rn_a, er); failures++; end checks++;
         if (done_a !== ed) begin $display("FAIL basic_done c=%0d got=%b exp=%b", c, done_a, ed); failures++; end checks++;
         if (csn_a !== ec) begin $display("FAIL basic_csn c=%0d got=%b exp=%b", c, csn_a, ec); failures++; end checks++;
         if (c == 17 && data_a !== 16'h0000) begin $display("FAIL basic_data_old got=%h exp=0000", data_a); failures++; end
         if (c == 17) checks++;
         if (c == 18 && data_a !== 16'h1234) begin $display("FAIL basic_data got=%h exp=1234", data_a); failures++; end
         if (c == 18) checks++;
         if (c == 18 && err_a !== 1'b0) begin $display("FAIL basic_err got=%b exp=0", err_a); failures++; end
         if (c == 18) checks++;
         if (c == 19 && busy_a !== 1'b0) begin $display("FAIL basic_busy got=%b exp=0", busy_a); failures++; end
         if (c == 19) checks++;
      end
      if (wr_n_a - w0 != 2) begin $display("FAIL basic_wr_count got=%0d exp=2", wr_n_a - w0); failures++; end checks++;
      if (rn_n_a - r0 != 2) begin $display("FAIL basic_rn_count got=%0d exp=2", rn_n_a - r0); failures++; end checks++;
      if (done_n_a - d0 != 1) begin $display("FAIL basic_done_count got=%0d exp=1", done_n_a - d0); failures++; end checks++;
      idle(2);
   endtask

   task automatic test_back_to_back;
      int w0;
      logic ew, er, ed, ec;
      w0 = wr_n_a;
      load(8'hA1, 0); load(8'hB2, 1); load(8'hC3, 2); load(8'hD4, 3);
      for (int c = 0; c <= 11; c++) begin
         @(negedge Clk_i);
         start_a = (c < 10); trans = 1'b0;
         #1;
         ew = (c == 0 || c == 1 || c == 5 || c == 6);
         er = (c == 3 || c == 4 || c == 8 || c == 9);
         ed = (c == 5 || c == 10);
         ec = (c >= 10);
         if (wr_a !== ew) begin $display("FAIL b2b_wr c=%0d got=%b exp=%b", c, wr_a, ew); failures++; end checks++;
         if (rn_a !== er) begin $display("FAIL b2b_rn c=%0d got=%b exp=%b", c, rn_a, er); failures++; end checks++;
         if (done_a !== ed) begin $display("FAIL b2b_done c=%0d got=%b exp=%b", c, done_a, ed); failures++; end checks++;
         if (csn_a !== ec) begin $display("FAIL b2b_csn c=%0d got=%b exp=%b", c, csn_a, ec); failures++; end checks++;
         if (c == 5 && data_a !== 16'hA1B2) begin $display("FAIL b2b_data1 got=%h exp=a1b2", data_a); failures++; end
         if (c == 5) checks++;
         if (c == 10 && data_a !== 16'hC3D4) begin $display("FAIL b2b_data2 got=%h exp=c3d4", data_a); failures++; end
         if (c == 10) checks++;
         if (c == 11 && busy_a !== 1'b0) begin $display("FAIL b2b_busy got=%b exp=0", busy_a); failures++; end
         if (c == 11) checks++;
      end
      if (wr_n_a - w0 != 4) begin $display("FAIL b2b_wr_count got=%0d exp=4", wr_n_a - w0); failures++; end checks++;
      idle(2);
   endtask

   task automatic test_reset_mid;
      int d0;
      d0 = done_n_a;
      load(8'h77, 0); load(8'h88, 1);
      for (int c = 0; c <= 4; c++) begin
         @(negedge Clk_i);
         start_a = (c == 0); trans = 1'b0;
      end
      #1;
      if (rn_a !== 1'b1) begin $display("FAIL rstmid_in_read got=%b exp=1", rn_a); failures++; end checks++;
      Reset_n_i = 1'b0;
      #1;
      if (csn_a !== 1'b1) begin $display("FAIL rstmid_csn got=%b exp=1", csn_a); failures++; end checks++;
      if (data_a !== 16'h0) begin $display("FAIL rstmid_data got=%h exp=0000", data_a); failures++; end checks++;
      if (busy_a !== 1'b0) begin $display("FAIL rstmid_busy got=%b exp=0", busy_a); failures++; end checks++;
      if (rn_a !== 1'b0) begin $display("FAIL rstmid_rn got=%b exp=0", rn_a); failures++; end checks++;
      #1;
      Reset_n_i = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge Clk_i);
         start_a = 1'b0;
         #1;
         if (done_a !== 1'b0) begin $display("FAIL rstmid_done c=%0d got=%b exp=0", c, done_a); failures++; end checks++;
         if (busy_a !== 1'b0) begin $display("FAIL rstmid_idle c=%0d got=%b exp=0", c, busy_a); failures++; end checks++;
      end
      if (done_n_a != d0) begin $display("FAIL rstmid_done_count got=%0d exp=%0d", done_n_a, d0); failures++; end checks++;
   endtask

   task automatic test_wide;
      logic [31:0] frames [2];
      logic [31:0] olds [2];
      logic ew, er, ed, ec;
      int w0, r0;
      frames[0] = 32'hDEADBEEF; frames[1] = 32'h01020304;
      olds[0]   = 32'h00000000; olds[1]   = 32'hDEADBEEF;
      for (int f = 0; f < 2; f++) begin
         w0 = wr_n_b; r0 = rn_n_b;
         for (int i = 0; i < 4; i++) load(frames[f][8*(3-i) +: 8], i);
         for (int c = 0; c <= 7; c++) begin
            @(negedge Clk_i);
            start_b = (c == 0); trans = 1'b0;
            #1;
            ew = (c == 0); er = (c >= 2 && c <= 5); ed = (c == 6); ec = (c >= 6);
            if (wr_b !== ew) begin $display("FAIL wide_wr f=%0d c=%0d got=%b exp=%b", f, c, wr_b, ew); failures++; end checks++;
            if (rn_b !== er) begin $display("FAIL wide_rn f=%0d c=%0d got=%b exp=%b", f, c, rn_b, er); failures++; end checks++;
            if (done_b !== ed) begin $display("FAIL wide_done f=%0d c=%0d got=%b exp=%b", f, c, done_b, ed); failures++; end checks++;
            if (csn_b !== ec) begin $display("FAIL wide_csn f=%0d c=%0d got=%b exp=%b", f, c, csn_b, ec); failures++; end checks++;
            if (c == 5 && data_b !== olds[f]) begin $display("FAIL wide_data_hold f=%0d got=%h exp=%h", f, data_b, olds[f]); failures++; end
            if (c == 5) checks++;
            if (c == 6 && data_b !== frames[f]) begin $display("FAIL wide_data f=%0d got=%h exp=%h", f, data_b, frames[f]); failures++; end
            if (c == 6) checks++;
         end
         if (wr_n_b - w0 != 1) begin $display("FAIL wide_wr_count f=%0d got=%0d exp=1", f, wr_n_b - w0); failures++; end checks++;
         if (rn_n_b - r0 != 4) begin $display("FAIL wide_rn_count f=%0d got=%0d exp=4", f, rn_n_b - r0); failures++; end checks++;
      end
      idle(2);
   endtask

   task automatic test_ignore_start;
      int w0, r0, d0;
      w0 = wr_n_a; r0 = rn_n_a; d0 = done_n_a;
      load(8'h5A, 0); load(8'h6B, 1);
      for (int c = 0; c <= 11; c++) begin
         @(negedge Clk_i);
         start_a = (c == 0 || c == 1 || c == 5); trans = (c < 8);
         #1;
         if (c == 10 && done_a !== 1'b1) begin $display("FAIL ign_done got=%b exp=1", done_a); failures++; end
         if (c == 10) checks++;
         if (c == 10 && data_a !== 16'h5A6B) begin $display("FAIL ign_data got=%h exp=5a6b", data_a); failures++; end
         if (c == 10) checks++;
         if (c == 11 && busy_a !== 1'b0) begin $display("FAIL ign_busy got=%b exp=0", busy_a); failures++; end
         if (c == 11) checks++;
      end
      if (wr_n_a - w0 != 2) begin $display("FAIL ign_wr_count got=%0d exp=2", wr_n_a - w0); failures++; end checks++;
      if (rn_n_a - r0 != 2) begin $display("FAIL ign_rn_count got=%0d exp=2", rn_n_a - r0); failures++; end checks++;
      if (done_n_a - d0 != 1) begin $display("FAIL ign_done_count got=%0d exp=1", done_n_a - d0); failures++; end checks++;
      idle(2);
   endtask

   task automatic test_stuck;
      int w0, r0, d0;
      w0 = wr_n_a; r0 = rn_n_a; d0 = done_n_a;
`ifdef SPI_SEQ_TIMEOUT_EN
      begin
         int hit_c;
         hit_c = -1;
         for (int c = 0; c <= 400 && hit_c < 0; c++) begin
            @(negedge Clk_i);
            start_a = (c == 0); trans = 1'b1;
            #1;
            if (done_a === 1'b1) begin
               hit_c = c;
               if (err_a !== 1'b1) begin $display("FAIL to_err got=%b exp=1", err_a); failures++; end checks++;
               if (csn_a !== 1'b1) begin $display("FAIL to_csn got=%b exp=1", csn_a); failures++; end checks++;
               if (data_a !== 16'h5A6B) begin $display("FAIL to_data got=%h exp=5a6b", data_a); failures++; end checks++;
            end
         end
         if (hit_c != 258) begin $display("FAIL to_latency got=%0d exp=258", hit_c); failures++; end checks++;
         if (rn_n_a != r0) begin $display("FAIL to_rn_count got=%0d exp=%0d", rn_n_a - r0, 0); failures++; end checks++;
         trans = 1'b0;
      end
`else
      for (int c = 0; c < 1000; c++) begin
         @(negedge Clk_i);
         start_a = (c == 0); trans = 1'b1;
      end
      #1;
      if (busy_a !== 1'b1) begin $display("FAIL stuck_busy got=%b exp=1", busy_a); failures++; end checks++;
      if (csn_a !== 1'b0) begin $display("FAIL stuck_csn got=%b exp=0", csn_a); failures++; end checks++;
      if (err_a !== 1'b0) begin $display("FAIL stuck_err got=%b exp=0", err_a); failures++; end checks++;
      if (done_n_a != d0) begin $display("FAIL stuck_done_count got=%0d exp=0", done_n_a - d0); failures++; end checks++;
      if (rn_n_a != r0) begin $display("FAIL stuck_rn_count got=%0d exp=0", rn_n_a - r0); failures++; end checks++;
      if (wr_n_a - w0 != 2) begin $display("FAIL stuck_wr_count got=%0d exp=2", wr_n_a - w0); failures++; end checks++;
      load(8'h11, 0); load(8'h22, 1);
      for (int c = 0; c <= 3; c++) begin
         @(negedge Clk_i);
         start_a = 1'b0; trans = 1'b0;
         #1;
         if (c == 2 && done_a !== 1'b1) begin $display("FAIL stuck_release_done got=%b exp=1", done_a); failures++; end
         if (c == 2) checks++;
         if (c == 2 && data_a !== 16'h1122) begin $display("FAIL stuck_release_data got=%h exp=1122", data_a); failures++; end
         if (c == 2) checks++;
      end
`endif
      idle(2);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 8'h00;
      test_reset;
      test_basic;
      test_back_to_back;
      test_reset_mid;
      test_wide;
      test_ignore_start;
      test_stuck;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
